mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4:1 single-bit mux datapath among four requesters.
//  Drives the mux select, exposes a one-hot grant, and registers the selected data bit.
//  Sits in front of the existing 4:1 mux; Sel is generated here rather than by the user.
// PARAMETERS
//  N_REQ     4   number of requesters; fixed at 4 to match a 2-bit mux select
//  SEL_W     2   select width, log2(N_REQ)
//  MAX_HOLD  8   max consecutive grant cycles while another req is pending; 0 = unlimited
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   4      per-requester request, level-sensitive
//  data_in    in   4      data bit of each requester (mux In)
//  grant      out  4      one-hot grant, registered; 0 when idle
//  sel        out  2      mux select, registered
//  busy       out  1      1 while any grant is active
//  data_out   out  1      registered data_in[sel]
//  out_valid  out  1      data_out holds a granted sample
// BEHAVIOUR
//  Reset (rst_n=0, async):
//  - state=IDLE; grant=0; sel=0; busy=0; data_out=0; out_valid=0.
//  - last=3, so requester 0 has first priority; hold_cnt=0.
//  - Reset asserted mid-grant clears everything immediately, without waiting for clk.
//  Round-robin pick:
//  - Search from (last+1) mod 4 upward with wrap; take the first set req bit.
//  IDLE:
//  - If req!=0 at edge k, grant/sel/busy are valid after edge k; state->GRANT; hold_cnt=1.
//  - If req==0, outputs hold; sel keeps its previous value.
//  GRANT (current index g=sel):
//  - Release when req[g]=0 at the edge:
//    - last<=g.
//    - If another req is pending, grant the next RR winner at that same edge; no idle gap.
//    - Otherwise grant=0, busy=0, state->IDLE.
//  - Preempt when req[g]=1, hold_cnt==MAX_HOLD (MAX_HOLD!=0) and another req is pending:
//    - last<=g; switch to the next RR winner; hold_cnt=1.
//  - Stay in all other cases; hold_cnt increments and saturates at MAX_HOLD.
//  - A new grant always resets hold_cnt to 1.
//  - Simultaneous requests: RR order decides; no requester is granted twice before the others.
//  Datapath:
//  - Every edge: data_out<=busy ? data_in[sel] : data_out.
//  - out_valid<=busy, i.e. 1-cycle latency after grant.
//  - data_out holds its last value when idle.
//  Invariants:
//  - grant is one-hot or zero.
//  - grant==(busy ? 1<<sel : 0).
//  - No combinational path from req to grant.
// TESTING
//  1 Reset: rst_n=0 with req=4'hF -> grant=0, sel=0, busy=0, data_out=0, out_valid=0.
//  2 Single: req=4'b0100, data_in=4'b0100 -> next edge grant=0100, sel=2; following edge data_out=1, out_valid=1.
//  3 Fairness: req=4'hF held, MAX_HOLD=8 -> sel sequence 0,1,2,3,0, each for exactly 8 cycles.
//  4 Handoff: grant=0001, req 4'b1001->4'b1000 -> next edge grant=1000, sel=3, busy stays 1.
//  5 Solo hold: req=4'b0010 for 20 cycles -> grant=0010 throughout; no preemption.
//  6 Async reset: assert rst_n=0 mid-cycle during grant=0100 -> outputs clear before next edge; after release, req=4'hF grants 0 first.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that drives the select of a shared 4:1 single-bit mux
// and registers the selected data bit.
module mux_rr_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data_in,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             data_out,
    output logic             out_valid
);

    localparam int unsigned      HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]    HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [SEL_W-1:0] last;
    logic [HW-1:0]    hold_cnt;
    logic [N_REQ-1:0] others;
    logic [SEL_W-1:0] pick_idle;
    logic [SEL_W-1:0] pick_next;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // First set bit of r searching upward from base+1, wrapping back to base.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [SEL_W-1:0] base);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        logic             found;
        win   = base;
        found = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = base + SEL_W'(i);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        others    = req & ~onehot(sel);
        pick_idle = rr_pick(req, last);
        pick_next = rr_pick(others, sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= '0;
            busy      <= 1'b0;
            data_out  <= 1'b0;
            out_valid <= 1'b0;
            last      <= SEL_LAST;
            hold_cnt  <= '0;
        end else begin
            data_out  <= busy ? data_in[sel] : data_out;
            out_valid <= busy;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        sel      <= pick_idle;
                        grant    <= onehot(pick_idle);
                        busy     <= 1'b1;
                        hold_cnt <= HW'(1);
                    end
                end
                GRANT: begin
                    // Release and preemption share the handoff path: the current
                    // holder becomes 'last' and the next winner is taken in the same edge.
                    if (!req[sel] || (MAX_HOLD != 0 && hold_cnt == HOLD_MAX && |others)) begin
                        last <= sel;
                        if (|others) begin
                            sel      <= pick_next;
                            grant    <= onehot(pick_next);
                            hold_cnt <= HW'(1);
                        end else begin
                            state    <= IDLE;
                            grant    <= '0;
                            busy     <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end else if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       data_out;
    logic       out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: current holder index (-1 when idle), etc.
    int         m_cur;
    int         m_last;
    int         m_hold;
    int         m_sel;
    logic       m_dout;
    logic       m_valid;

    mux_rr_arbiter #(.N_REQ(4), .SEL_W(2), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(grant), .sel(sel), .busy(busy),
        .data_out(data_out), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_first(input logic [3:0] r, input int base);
        for (int k = 1; k <= 4; k++) begin
            if (r[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [8:0] model_vec();
        logic [3:0] g;
        g = '0;
        if (m_cur >= 0) g[m_cur] = 1'b1;
        return {g, 2'(m_sel), (m_cur >= 0), m_dout, m_valid};
    endfunction

    task automatic model_reset();
        m_cur = -1; m_last = 3; m_hold = 0; m_sel = 0; m_dout = 1'b0; m_valid = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] oth;
        if (m_cur >= 0) m_dout = data_in[m_cur];
        m_valid = (m_cur >= 0);
        if (m_cur < 0) begin
            if (req != 4'b0) begin
                m_cur = rr_first(req, m_last); m_sel = m_cur; m_hold = 1;
            end
        end else begin
            oth = req;
            oth[m_cur] = 1'b0;
            if (!req[m_cur] || (m_hold == 8 && oth != 4'b0)) begin
                m_last = m_cur;
                if (oth != 4'b0) begin
                    m_cur = rr_first(oth, m_last); m_sel = m_cur; m_hold = 1;
                end else begin
                    m_cur = -1; m_hold = 0;
                end
            end else if (m_hold < 8) begin
                m_hold++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 4'hF; data_in = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({grant, sel, busy, data_out, out_valid} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", {grant, sel, busy, data_out, out_valid}, 9'b0);
        end
        @(negedge clk);
        req = 4'h0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        reset_dut();
        req = 4'b0100; data_in = 4'b0100;
        tick();
        n_tests++;
        if (grant !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got grant=%b sel=%0d busy=%b expected grant=0100 sel=2 busy=1", grant, sel, busy);
        end
        @(negedge clk);
        tick();
        n_tests++;
        if (data_out !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_data: got data_out=%b out_valid=%b expected 1 1", data_out, out_valid);
        end
    endtask

    task automatic test_fairness();
        int exp_sel;
        reset_dut();
        req = 4'hF;
        for (int i = 0; i < 40; i++) begin
            data_in = 4'($urandom);
            tick();
            exp_sel = (i / 8) % 4;
            n_tests++;
            if (busy !== 1'b1 || sel !== 2'(exp_sel) || {grant, sel, busy, data_out, out_valid} !== model_vec()) begin
                n_fail++;
                $display("FAIL fairness_cycle%0d: got sel=%0d busy=%b vec=%b expected sel=%0d busy=1 vec=%b",
                         i, sel, busy, {grant, sel, busy, data_out, out_valid}, exp_sel, model_vec());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_handoff();
        reset_dut();
        req = 4'b0001;
        tick();
        @(negedge clk);
        req = 4'b1001;
        tick();
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL handoff_pre: got grant=%b expected 0001", grant);
        end
        @(negedge clk);
        req = 4'b1000;
        tick();
        n_tests++;
        if (grant !== 4'b1000 || sel !== 2'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL handoff: got grant=%b sel=%0d busy=%b expected grant=1000 sel=3 busy=1", grant, sel, busy);
        end
    endtask

    task automatic test_solo_hold();
        int bad;
        reset_dut();
        req = 4'b0010;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant !== 4'b0010) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL solo_hold: got %0d cycles with grant!=0010 expected 0", bad);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        req = 4'b0100;
        tick();
        n_tests++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL async_pre: got grant=%b expected 0100", grant);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({grant, sel, busy, data_out, out_valid} !== 9'b0) begin
            n_fail++;
            $display("FAIL async_clear: got %b expected %b", {grant, sel, busy, data_out, out_valid}, 9'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'hF;
        tick();
        n_tests++;
        if (grant !== 4'b0001 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL async_first: got grant=%b sel=%0d expected grant=0001 sel=0", grant, sel);
        end
    endtask

    task automatic test_random();
        logic [3:0] g;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            data_in = 4'($urandom);
            tick();
            n_tests++;
            if ({grant, sel, busy, data_out, out_valid} !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %b expected %b", i, {grant, sel, busy, data_out, out_valid}, model_vec());
            end
            g = busy ? (4'b0001 << sel) : 4'b0000;
            n_tests++;
            if (grant !== g) begin
                n_fail++;
                $display("FAIL grant_invariant%0d: got %b expected %b", i, grant, g);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0; data_in = 4'b0;
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_handoff();
        test_solo_hold();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
